// File: rtl/pattern_stream_gen.sv
// pattern_stream_gen: serialises a latched DATA_W-bit word into OUT_W-bit chunks and repeats it
// N times (MODE=0), or emits N words of Fibonacci-LFSR pseudo-random bits (MODE=1).
//
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   IN, N, MODE     pattern word, word count, mode; sampled when START is accepted in IDLE
//   SEED            LFSR seed, sampled with START (zero is replaced by all-ones)
//   START, ABORT    run request (IDLE only) / early termination (SHIFT only)
//   out_ready       downstream ready; a handshake is pattern_valid && out_ready
//   pattern         current chunk (registered)
//   pattern_valid   pattern holds a chunk to be consumed
//   busy            high in SHIFT and DONE
//   done            one-cycle end-of-run pulse
//   word_cnt        words completed in the current run
module pattern_stream_gen #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       OUT_W     = 8,
  parameter int unsigned       CNT_W     = 8,
  parameter int unsigned       LFSR_W    = 31,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 31'h48000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] IN,
  input  logic [CNT_W-1:0]  N,
  input  logic              MODE,
  input  logic [LFSR_W-1:0] SEED,
  input  logic              START,
  input  logic              ABORT,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  pattern,
  output logic              pattern_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int unsigned CH     = DATA_W / OUT_W;
  localparam int unsigned CIDX_W = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CIDX_W-1:0] LastIdx = CIDX_W'(CH - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [CIDX_W-1:0] chunk_idx_q, chunk_idx_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [OUT_W-1:0]  pattern_q, pattern_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              start_acc;
  logic              hs;
  logic              word_end;
  logic [CNT_W-1:0]  cnt_inc;
  logic [LFSR_W-1:0] seed_eff;
  logic [LFSR_W-1:0] lfsr_src;
  logic [LFSR_W-1:0] lfsr_adv;
  logic [OUT_W-1:0]  lfsr_bits;
  logic              lfsr_fb;

  assign start_acc = (state_q == StIdle) && START;
  assign hs        = valid_q && out_ready;
  assign word_end  = hs && (chunk_idx_q == LastIdx);
  assign cnt_inc   = word_cnt_q + 1'b1;
  assign seed_eff  = (SEED == '0) ? '1 : SEED;

  // Unroll OUT_W LFSR steps: the first chunk comes straight from the seed, later ones from the
  // running state, so the LFSR is never reseeded between words.
  always_comb begin
    lfsr_src  = start_acc ? seed_eff : lfsr_q;
    lfsr_adv  = lfsr_src;
    lfsr_bits = '0;
    lfsr_fb   = 1'b0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      lfsr_fb      = ^(lfsr_adv & LFSR_TAPS);
      lfsr_bits[i] = lfsr_fb;
      lfsr_adv     = {lfsr_adv[LFSR_W-2:0], lfsr_fb};
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    shreg_d     = shreg_q;
    lfsr_d      = lfsr_q;
    mode_d      = mode_q;
    n_d         = n_q;
    chunk_idx_d = chunk_idx_q;
    word_cnt_d  = word_cnt_q;
    pattern_d   = pattern_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        pattern_d = '0;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        if (START) begin
          word_d      = IN;
          n_d         = N;
          mode_d      = MODE;
          lfsr_d      = seed_eff;
          word_cnt_d  = '0;
          chunk_idx_d = '0;
          busy_d      = 1'b1;
          if (N == '0) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StShift;
            valid_d = 1'b1;
            shreg_d = IN;
            if (MODE) begin
              pattern_d = lfsr_bits;
              lfsr_d    = lfsr_adv;
            end else begin
              pattern_d = IN[OUT_W-1:0];
            end
          end
        end
      end

      StShift: begin
        if (hs) begin
          chunk_idx_d = word_end ? '0 : chunk_idx_q + 1'b1;
          // Reload from the latched word so a live IN change cannot leak into the run.
          shreg_d     = word_end ? word_q : (shreg_q >> OUT_W);
          lfsr_d      = lfsr_adv;
          pattern_d   = mode_q ? lfsr_bits : shreg_d[OUT_W-1:0];
          if (word_end) begin
            word_cnt_d = cnt_inc;
          end
        end
        if ((word_end && (cnt_inc == n_q)) || ABORT) begin
          state_d = StDone;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end
      end

      StDone: begin
        state_d   = StIdle;
        busy_d    = 1'b0;
        valid_d   = 1'b0;
        pattern_d = '0;
      end

      default: begin
        state_d   = StIdle;
        busy_d    = 1'b0;
        valid_d   = 1'b0;
        pattern_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      word_q      <= '0;
      shreg_q     <= '0;
      lfsr_q      <= '0;
      mode_q      <= 1'b0;
      n_q         <= '0;
      chunk_idx_q <= '0;
      word_cnt_q  <= '0;
      pattern_q   <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      shreg_q     <= shreg_d;
      lfsr_q      <= lfsr_d;
      mode_q      <= mode_d;
      n_q         <= n_d;
      chunk_idx_q <= chunk_idx_d;
      word_cnt_q  <= word_cnt_d;
      pattern_q   <= pattern_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pattern       = pattern_q;
  assign pattern_valid = valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_pattern_stream_gen.sv
// Directed bench for pattern_stream_gen: a default 32/8 instance for repeat-mode, backpressure,
// abort, reset and count boundaries, plus a 8/1 instance with a 7-bit LFSR for random mode.
module tb_pattern_stream_gen;

  logic        CLK;
  logic        RST;

  // Default-parameter instance
  logic [31:0] IN;
  logic [7:0]  N;
  logic        MODE;
  logic [30:0] SEED;
  logic        START;
  logic        ABORT;
  logic        out_ready;
  logic [7:0]  pattern;
  logic        pattern_valid;
  logic        busy;
  logic        done;
  logic [7:0]  word_cnt;

  // LFSR instance
  logic [7:0]  l_in;
  logic [7:0]  l_n;
  logic        l_mode;
  logic [6:0]  l_seed;
  logic        l_start;
  logic        l_abort;
  logic        l_ready;
  logic [0:0]  l_pattern;
  logic        l_valid;
  logic        l_busy;
  logic        l_done;
  logic [7:0]  l_word_cnt;

  int checks = 0;
  int passed = 0;

  pattern_stream_gen dut (
    .CLK          (CLK),
    .RST          (RST),
    .IN           (IN),
    .N            (N),
    .MODE         (MODE),
    .SEED         (SEED),
    .START        (START),
    .ABORT        (ABORT),
    .out_ready    (out_ready),
    .pattern      (pattern),
    .pattern_valid(pattern_valid),
    .busy         (busy),
    .done         (done),
    .word_cnt     (word_cnt)
  );

  pattern_stream_gen #(
    .DATA_W   (8),
    .OUT_W    (1),
    .CNT_W    (8),
    .LFSR_W   (7),
    .LFSR_TAPS(7'h60)
  ) dut_l (
    .CLK          (CLK),
    .RST          (RST),
    .IN           (l_in),
    .N            (l_n),
    .MODE         (l_mode),
    .SEED         (l_seed),
    .START        (l_start),
    .ABORT        (l_abort),
    .out_ready    (l_ready),
    .pattern      (l_pattern),
    .pattern_valid(l_valid),
    .busy         (l_busy),
    .done         (l_done),
    .word_cnt     (l_word_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] chunk_of(input logic [31:0] w, input int idx);
    return w[8*(idx % 4) +: 8];
  endfunction

  logic [6:0] mst;
  logic       mfb;
  logic       model_bits [256];
  logic       dut_bits   [256];
  int         idx;
  int         k;
  int         hs_cnt;
  int         run;
  int         max_run;
  logic       saw_done;
  logic [3:0] rdy_pat;

  initial begin
    RST = 1'b1;
    IN = '0; N = '0; MODE = 1'b0; SEED = '0; START = 1'b0; ABORT = 1'b0; out_ready = 1'b0;
    l_in = '0; l_n = '0; l_mode = 1'b0; l_seed = '0; l_start = 1'b0; l_abort = 1'b0;
    l_ready = 1'b1;
    rdy_pat = 4'b1001;  // bit k%4 gives out_ready: 1,0,0,1

    #3;
    chk("rst_pattern", pattern, 0);
    chk("rst_valid", pattern_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_word_cnt", word_cnt, 0);
    step();
    RST = 1'b0;
    step();

    // Repeat mode, always ready
    IN = 32'hDDCCBBAA; N = 8'd2; MODE = 1'b0; out_ready = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t1_pattern", pattern, chunk_of(32'hDDCCBBAA, i));
      chk("t1_valid", pattern_valid, 1);
      chk("t1_busy", busy, 1);
      step();
    end
    chk("t1_done", done, 1);
    chk("t1_valid_done", pattern_valid, 0);
    chk("t1_word_cnt", word_cnt, 2);
    chk("t1_busy_done", busy, 1);
    step();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle_busy", busy, 0);
    step();

    // Repeat mode with ready toggling 1,0,0,1
    out_ready = 1'b1; START = 1'b1;
    step();
    START = 1'b0;
    idx = 0;
    k = 0;
    while (idx < 8 && k < 40) begin
      chk("t2_pattern", pattern, chunk_of(32'hDDCCBBAA, idx));
      chk("t2_valid", pattern_valid, 1);
      out_ready = rdy_pat[k % 4];
      step();
      if (out_ready) idx++;
      k++;
    end
    chk("t2_all_chunks", idx, 8);
    chk("t2_done", done, 1);
    chk("t2_valid_done", pattern_valid, 0);
    chk("t2_word_cnt", word_cnt, 2);
    out_ready = 1'b1;
    step();
    chk("t2_done_pulse", done, 0);
    step();

    // N = 0
    N = 8'd0; START = 1'b1;
    step();
    START = 1'b0;
    chk("t3_done", done, 1);
    chk("t3_valid", pattern_valid, 0);
    chk("t3_word_cnt", word_cnt, 0);
    step();
    chk("t3_done_pulse", done, 0);
    chk("t3_valid_after", pattern_valid, 0);
    step();

    // LFSR mode, seed 0 -> 7'h7F
    mst = 7'h7F;
    for (int i = 0; i < 256; i++) begin
      mfb = mst[6] ^ mst[5];
      model_bits[i] = mfb;
      mst = {mst[5:0], mfb};
    end
    l_mode = 1'b1; l_seed = 7'h00; l_n = 8'd32; l_in = 8'h5A; l_start = 1'b1;
    step();
    l_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      chk("t4_valid", l_valid, 1);
      chk("t4_bit", l_pattern, model_bits[i]);
      dut_bits[i] = l_pattern[0];
      step();
    end
    for (int i = 127; i < 256; i++) begin
      chk("t4_period", dut_bits[i], model_bits[i-127]);
    end
    run = 0;
    max_run = 0;
    for (int i = 0; i < 256; i++) begin
      run = dut_bits[i] ? 0 : run + 1;
      if (run > max_run) max_run = run;
    end
    chk("t4_zero_run_le6", (max_run <= 6), 1);
    chk("t4_done", l_done, 1);
    chk("t4_word_cnt", l_word_cnt, 32);
    step();

    // Mid-run: ignored START, live IN change, ABORT
    IN = 32'h04030201; N = 8'd5; MODE = 1'b0; out_ready = 1'b1; START = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      chk("t5_pattern", pattern, chunk_of(32'h04030201, i));
      chk("t5_valid", pattern_valid, 1);
      chk("t5_word_cnt", word_cnt, (i >= 4) ? 1 : 0);
      if (i == 0) begin
        IN = 32'hAABBCCDD; N = 8'd1;
      end
      if (i == 1) START = 1'b0;
      if (i == 6) ABORT = 1'b1;
      step();
    end
    ABORT = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_valid_abort", pattern_valid, 0);
    chk("t5_word_cnt_abort", word_cnt, 1);
    step();
    chk("t5_done_pulse", done, 0);
    chk("t5_idle_busy", busy, 0);
    step();

    // Asynchronous reset in SHIFT, then a fresh run
    IN = 32'hDDCCBBAA; N = 8'd2; START = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    chk("t6_pre_pattern", pattern, 8'hCC);
    RST = 1'b1;
    #1;
    chk("t6_rst_pattern", pattern, 0);
    chk("t6_rst_valid", pattern_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_word_cnt", word_cnt, 0);
    #1;
    RST = 1'b0;
    step();
    IN = 32'h44332211; N = 8'd1; START = 1'b1;
    step();
    START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t6_pattern", pattern, chunk_of(32'h44332211, i));
      chk("t6_valid", pattern_valid, 1);
      step();
    end
    chk("t6_done", done, 1);
    chk("t6_word_cnt", word_cnt, 1);
    step();
    step();

    // N = 255: no wrap of word_cnt
    IN = 32'h12345678; N = 8'd255; START = 1'b1;
    step();
    START = 1'b0;
    hs_cnt = 0;
    k = 0;
    saw_done = 1'b0;
    while (!saw_done && k < 1100) begin
      if (pattern_valid) hs_cnt++;
      step();
      k++;
      if (done) saw_done = 1'b1;
    end
    chk("t7_done_seen", saw_done, 1);
    chk("t7_handshakes", hs_cnt, 1020);
    chk("t7_word_cnt", word_cnt, 255);
    chk("t7_valid_done", pattern_valid, 0);
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pattern_stream_gen.md
Name: pattern_stream_gen

Overview:
- Parametrised successor to the byte-pattern repeater used in the ADI test datapath.
- Serialises a DATA_W-bit word into OUT_W-bit chunks and repeats it N times (MODE=0), or emits an LFSR pseudo-random stream of N words (MODE=1).
- Adds a start/done control pair, valid/ready backpressure on the output, abort, and a live word count.
- Feeds the downstream pattern checker and the TX lane muxes.

Parameters:
- DATA_W, 32: input word width; must be an integer multiple of OUT_W.
- OUT_W, 8: output chunk width.
- CNT_W, 8: width of the repeat count N and of word_cnt.
- LFSR_W, 31: LFSR state width.
- LFSR_TAPS, 31'h48000000: feedback tap mask, bit i set means state bit i is XORed into feedback (default x^31+x^28+1).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IN  in  DATA_W  pattern word, sampled on an accepted START.
- N  in  CNT_W  number of words to emit, sampled on an accepted START.
- MODE  in  1  0 = repeat IN, 1 = LFSR; sampled on an accepted START.
- SEED  in  LFSR_W  LFSR seed, sampled on an accepted START.
- START  in  1  request a run; accepted only in IDLE.
- ABORT  in  1  terminate the current run.
- out_ready  in  1  downstream ready.
- pattern  out  OUT_W  current chunk.
- pattern_valid  out  1  pattern is valid.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle end-of-run pulse.
- word_cnt  out  CNT_W  words completed in the current run.

Behaviour:
- RST high, at any time including mid-run: state goes to IDLE; pattern=0, pattern_valid=0, busy=0, done=0, word_cnt=0; internal word and LFSR registers cleared. Asynchronous assert, synchronous release.
- All outputs are registered.
- CH = DATA_W/OUT_W chunks per word. chunk_idx has width clog2(CH), minimum 1.
- A handshake occurs on a cycle where pattern_valid && out_ready.
- IDLE:
  - Outputs low.
  - START=1 latches IN, N, MODE and SEED, clears word_cnt and chunk_idx.
  - If N==0, go to DONE. Else go to SHIFT; on the next edge pattern holds the first chunk and pattern_valid=1 (latency one cycle from START).
- SHIFT:
  - pattern and pattern_valid stay stable until a handshake.
  - On a handshake, the next chunk is presented in the following cycle with no bubble. Back-to-back throughput is one chunk per cycle while out_ready=1.
  - After the handshake on chunk CH-1: chunk_idx wraps to 0 and word_cnt increments.
  - If word_cnt+1==N, go to DONE with pattern_valid=0 in that cycle. word_cnt equals N in DONE.
- MODE 0:
  - A chunk register is loaded with the word and shifted right by OUT_W per handshake.
  - pattern = low OUT_W bits, i.e. LSB chunk first.
  - At word end the register reloads from the latched word, not the live IN.
- MODE 1:
  - Fibonacci LFSR. Feedback fb = XOR-reduce(state & LFSR_TAPS); next state = {state[LFSR_W-2:0], fb}.
  - Each chunk is OUT_W consecutive fb bits, bit 0 the earliest. The LFSR advances OUT_W steps per handshake and is computed combinationally for the next chunk.
  - SEED==0 is replaced by all-ones at latch time.
  - The LFSR is not reseeded between words.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. START in DONE is ignored.
- START while in SHIFT or DONE is ignored, with no relatch.
- ABORT in SHIFT: next state DONE, pattern_valid drops on the next edge, done pulses, word_cnt frozen. A handshake in the abort cycle still counts. ABORT in IDLE or DONE has no effect. ABORT and START together in IDLE: START wins.
- N = 2^CNT_W-1 is legal; word_cnt never wraps within a run.

Test Plan:
- MODE=0, IN=32'hDDCCBBAA, N=2, out_ready=1, START pulse: pattern AA,BB,CC,DD,AA,BB,CC,DD on 8 consecutive cycles starting 1 cycle after START. Then done pulses one cycle with pattern_valid=0, word_cnt=2, and the block returns to IDLE.
- Same stimulus with out_ready toggling 1,0,0,1 repeating: each chunk holds stable while not ready, no chunk is skipped or duplicated, and the sequence and done timing are otherwise identical.
- N=0 with START: no pattern_valid at any time; done is high the cycle after START; word_cnt=0.
- MODE=1 with LFSR_W=7, LFSR_TAPS=7'h60, OUT_W=1, DATA_W=8, SEED=0, N=32: the bitstream matches a bit-accurate reference model seeded 7'h7F, the first 127 bits repeat at bit 127, and no all-zero run is longer than 6.
- Mid-run events with IN=32'h04030201, N=5:
  - ABORT after the 6th handshake: done pulses, word_cnt=1.
  - A second START during SHIFT is ignored.
  - A new IN value applied mid-run does not change the emitted data.
- RST asserted during SHIFT: all outputs are 0 immediately without waiting for a clock edge. After release, a fresh START runs normally from chunk 0.
